// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling rate and width helper.
// Imported by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OS_RATE       = 16;
  localparam int DEFAULT_DBITS = 8;

  // Counter width able to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: free-running divider with enable and clear.
// Tick is only ever asserted while enabled.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DIV_W = clog2_min1(CLKS_PER_TICK);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_TICK - 1);

  logic [DIV_W-1:0] r_div;

  assign o_tick = i_en & ~i_clr & (r_div == DIV_MAX);

  // Divider count: cleared on request, wraps after the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (i_clr) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= o_tick ? '0 : (r_div + DIV_W'(1));
    end else begin
      r_div <= r_div;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DBITS data bits LSB first, SB_TICKS/16 stop bits.
// Bit timing is 16 oversampling ticks per bit from uart_baud_gen.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBITS         = DEFAULT_DBITS,
  parameter int CLKS_PER_TICK = 27,
  parameter int SB_TICKS      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [DBITS-1:0] tx_din,
  output logic             tx_ready,
  output logic             tx_done,
  output logic             tx
);

  localparam int OS_MAX = (SB_TICKS > OS_RATE) ? SB_TICKS : OS_RATE;
  localparam int OS_W   = clog2_min1(OS_MAX);
  localparam int BIT_W  = clog2_min1(DBITS);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
  localparam logic [OS_W-1:0]  SB_LAST  = OS_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DBITS - 1);

  uart_state_e      r_state, w_state_next;
  logic [DBITS-1:0] r_shift, w_shift_next;
  logic [OS_W-1:0]  r_os_cnt, w_os_next;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_next;
  logic             r_tx, w_tx_next;
  logic             w_done;
  logic             w_tick;
  logic             w_idle;

  assign w_idle = (r_state == ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (~w_idle),
    .i_clr  (w_idle),
    .o_tick (w_tick)
  );

  // State register plus shift register, counters and the registered line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_os_cnt  <= w_os_next;
      r_bit_cnt <= w_bit_next;
      r_tx      <= w_tx_next;
    end
  end

  // Next-state, counter and done-pulse logic.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_os_next    = r_os_cnt;
    w_bit_next   = r_bit_cnt;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_state_next = ST_START;
          w_shift_next = tx_din;
          w_os_next    = '0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_next    = '0;
            w_bit_next   = '0;
            w_state_next = ST_DATA;
          end else begin
            w_os_next = r_os_cnt + OS_W'(1);
          end
        end else begin
          w_os_next = r_os_cnt;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_os_cnt == OS_LAST) begin
            w_os_next    = '0;
            w_shift_next = r_shift >> 1;
            if (r_bit_cnt == BIT_LAST) begin
              w_state_next = ST_STOP;
            end else begin
              w_bit_next = r_bit_cnt + BIT_W'(1);
            end
          end else begin
            w_os_next = r_os_cnt + OS_W'(1);
          end
        end else begin
          w_os_next = r_os_cnt;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_os_cnt == SB_LAST) begin
            w_done       = 1'b1;
            w_os_next    = '0;
            w_state_next = ST_IDLE;
          end else begin
            w_os_next = r_os_cnt + OS_W'(1);
          end
        end else begin
          w_os_next = r_os_cnt;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line value for the coming cycle follows the state being entered.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      ST_IDLE:  w_tx_next = 1'b1;
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      ST_STOP:  w_tx_next = 1'b1;
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign tx       = r_tx;
  assign tx_ready = w_idle;
  assign tx_done  = w_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle waveform model, frame-bit table,
// back-to-back, busy-ignore, mid-frame reset and a 16x oversampling decoder.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [7:0] din1, din2;
  logic       ready1, done1, tx1;
  logic       ready2, done2, tx2;
  logic       sel;
  logic       w_tx, w_ready, w_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  uart_tx #(.DBITS(8), .CLKS_PER_TICK(4), .SB_TICKS(16)) dut1 (
    .clk(clk), .rst(rst), .tx_start(start1), .tx_din(din1),
    .tx_ready(ready1), .tx_done(done1), .tx(tx1)
  );

  uart_tx #(.DBITS(8), .CLKS_PER_TICK(1), .SB_TICKS(32)) dut2 (
    .clk(clk), .rst(rst), .tx_start(start2), .tx_din(din2),
    .tx_ready(ready2), .tx_done(done2), .tx(tx2)
  );

  assign w_tx    = sel ? tx2 : tx1;
  assign w_ready = sel ? ready2 : ready1;
  assign w_done  = sel ? done2 : done1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line level k clocks after acceptance: start, LSB-first data, then stop.
  function automatic logic model_line(input logic [7:0] b, input int k, input int c);
    int idx;
    idx = (k - 1) / (16 * c);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    logic [9:0] f;
    f[9] = 1'b0;
    for (int i = 0; i < 8; i++) f[8-i] = b[i];
    f[0] = 1'b1;
    return f;
  endfunction

  task automatic drive_start(input logic v, input logic [7:0] d);
    if (sel) begin start2 = v; din2 = d; end
    else begin start1 = v; din1 = d; end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit hold, input bit disturb,
                           input int abort_at, output logic [9:0] seen);
    int c, sb, bitlen, frame, idx;
    c      = sel ? 1 : 4;
    sb     = sel ? 32 : 16;
    bitlen = 16 * c;
    frame  = 9 * bitlen + sb * c;
    seen   = '1;
    @(negedge clk);
    check("ready_before_frame", {31'd0, w_ready}, 32'd1);
    check("line_before_frame", {31'd0, w_tx}, 32'd1);
    drive_start(1'b1, b);
    @(posedge clk);
    #1;
    if (!hold) drive_start(1'b0, b);
    for (int k = 1; k <= frame; k++) begin
      @(negedge clk);
      check($sformatf("line k=%0d", k), {31'd0, w_tx}, {31'd0, model_line(b, k, c)});
      check($sformatf("done k=%0d", k), {31'd0, w_done}, {31'd0, (k == frame)});
      check($sformatf("ready_busy k=%0d", k), {31'd0, w_ready}, 32'd0);
      idx = k / bitlen;
      if ((k % bitlen) == (bitlen / 2) && idx <= 9) seen[9-idx] = w_tx;
      if (disturb) begin
        if (sel) begin start2 = (k == 100); din2 = (k == 100) ? 8'h3C : 8'($urandom); end
        else begin start1 = (k == 100); din1 = (k == 100) ? 8'h3C : 8'($urandom); end
      end
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_tx", {31'd0, w_tx}, 32'd1);
        check("abort_ready", {31'd0, w_ready}, 32'd1);
        check("abort_done", {31'd0, w_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    if (disturb) drive_start(1'b0, 8'h00);
  endtask

  task automatic decode_16x(output logic [7:0] got);
    bit found;
    found = 1'b0;
    got   = '0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (w_tx == 1'b0) found = 1'b1;
    end
    check("dec_start_found", {31'd0, found}, 32'd1);
    if (!found) return;
    repeat (7) @(negedge clk);
    check("dec_start_mid", {31'd0, w_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      got[i] = w_tx;
    end
    repeat (16) @(negedge clk);
    check("dec_stop_mid", {31'd0, w_tx}, 32'd1);
  endtask

  initial begin
    logic [9:0] seen;
    logic [7:0] b, got;
    int         pulses, lows;

    vecs[0] = '{8'hA5, 10'b0101001011};
    vecs[1] = '{8'h00, 10'b0000000001};
    vecs[2] = '{8'hFF, 10'b0111111111};
    vecs[3] = '{8'h55, 10'b0101010101};
    vecs[4] = '{8'h3C, 10'b0001111001};

    rst = 1'b1; sel = 1'b0;
    start1 = 1'b0; start2 = 1'b0; din1 = 8'h00; din2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset pulse while idle.
    #2;
    rst = 1'b1;
    #1;
    check("rst_tx", {31'd0, tx1}, 32'd1);
    check("rst_ready", {31'd0, ready1}, 32'd1);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_tx2", {31'd0, tx2}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].din, 1'b0, 1'b0, 0, seen);
      check($sformatf("table_line din=%0h", vecs[i].din), {22'd0, seen}, {22'd0, vecs[i].line});
    end

    // Back-to-back with tx_start held high.
    run_frame(8'h00, 1'b1, 1'b0, 0, seen);
    check("b2b_first", {22'd0, seen}, {22'd0, 10'b0000000001});
    run_frame(8'hFF, 1'b0, 1'b0, 0, seen);
    check("b2b_second", {22'd0, seen}, {22'd0, 10'b0111111111});

    // Busy start request and toggling data must not disturb the frame.
    run_frame(8'hA5, 1'b0, 1'b1, 0, seen);
    check("busy_ignore_line", {22'd0, seen}, {22'd0, 10'b0101001011});
    lows = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (tx1 == 1'b0 || ready1 == 1'b0) lows++;
    end
    check("no_second_frame", lows, 32'd0);

    // Mid-frame reset abandons the frame.
    run_frame(8'hA5, 1'b0, 1'b0, 200, seen);
    pulses = 0; lows = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done1) pulses++;
      if (!tx1) lows++;
    end
    check("abort_no_done", pulses, 32'd0);
    check("abort_line_high", lows, 32'd0);
    run_frame(8'h55, 1'b0, 1'b0, 0, seen);
    check("after_abort_line", {22'd0, seen}, {22'd0, 10'b0101010101});

    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      run_frame(b, 1'b0, 1'b0, 0, seen);
      check($sformatf("random_line din=%0h", b), {22'd0, seen}, {22'd0, frame_bits(b)});
    end

    // One clock per tick, two stop bits, checked by an oversampling decoder.
    sel = 1'b1;
    fork
      run_frame(8'h81, 1'b0, 1'b0, 0, seen);
      decode_16x(got);
    join
    check("fast_decode", {24'd0, got}, 32'h81);
    check("fast_line", {22'd0, seen}, {22'd0, frame_bits(8'h81)});
    b = 8'($urandom);
    fork
      run_frame(b, 1'b0, 1'b0, 0, seen);
      decode_16x(got);
    join
    check($sformatf("fast_decode_rand din=%0h", b), {24'd0, got}, {24'd0, b});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
